// File: rtl/mult_arbiter_pkg.sv
// Shared widths, slot state and requester index type for the two-port
// arbitrated fixed-point multiplier.
package mult_arbiter_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int FRAC_DEF  = 4;
  localparam int NUM_REQ   = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  typedef logic req_idx_t;

  function automatic logic [NUM_REQ-1:0] req_onehot(input req_idx_t r);
    req_onehot    = '0;
    req_onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Operand and result handshake bundle. The a_i LSB weight is 2^-frac_p,
// so product_o carries frac_p fractional bits as well.
interface mult_arbiter_if
  import mult_arbiter_pkg::*;
#(
  parameter int width_p = WIDTH_DEF,
  parameter int frac_p  = FRAC_DEF
);

  logic [NUM_REQ-1:0]                       valid_i;
  logic [NUM_REQ-1:0]                       ready_o;
  logic [NUM_REQ-1:0][width_p+frac_p-1:0]   a_i;
  logic [NUM_REQ-1:0][width_p-1:0]          b_i;
  logic [NUM_REQ-1:0]                       valid_o;
  logic [NUM_REQ-1:0]                       ready_i;
  logic [2*width_p+frac_p-1:0]              product_o;

  modport master (
    output valid_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, product_o
  );

  modport slave (
    input  valid_i, a_i, b_i, ready_i,
    output ready_o, valid_o, product_o
  );

endinterface

// File: rtl/mult_arbiter_multiplier.sv
// Full-precision unsigned combinational multiplier.
module mult_arbiter_multiplier #(
  parameter int a_w = 12,
  parameter int b_w = 8
) (
  input  logic [a_w-1:0]     a_i,
  input  logic [b_w-1:0]     b_i,
  output logic [a_w+b_w-1:0] product_o
);

  localparam int P_W = a_w + b_w;

  assign product_o = P_W'(a_i) * P_W'(b_i);

endmodule

// File: rtl/mult_arbiter.sv
// Two requesters share one multiplier behind a round-robin grant and a
// single result slot; a drain and a new accept may share a cycle.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int width_p = WIDTH_DEF,
  parameter int frac_p  = FRAC_DEF
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  mult_arbiter_if.slave bus
);

  localparam int A_W = width_p + frac_p;
  localparam int P_W = 2*width_p + frac_p;

  slot_state_e         state_q, state_d;
  req_idx_t            owner_q, last_q, grant;
  logic [P_W-1:0]      prod_q, mult_out;
  logic [A_W-1:0]      a_sel;
  logic [width_p-1:0]  b_sel;
  logic [NUM_REQ-1:0]  ready;
  logic                any_valid, slot_free, accept;

  // Contention goes to whoever did not win last time.
  always_comb begin
    grant = 1'b0;
    unique case (bus.valid_i)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_q;
      default: grant = 1'b0;
    endcase
  end

  assign any_valid = |bus.valid_i;
  // ready_i on a non-owner bit is deliberately ignored here.
  assign slot_free = (state_q == EMPTY) || bus.ready_i[owner_q];

  always_comb begin
    ready = '0;
    if (reset_ni && any_valid)
      ready[grant] = slot_free;
  end

  assign accept = bus.valid_i[grant] && ready[grant];
  assign a_sel  = bus.a_i[grant];
  assign b_sel  = bus.b_i[grant];

  mult_arbiter_multiplier #(
    .a_w (A_W),
    .b_w (width_p)
  ) u_mult (
    .a_i       (a_sel),
    .b_i       (b_sel),
    .product_o (mult_out)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)                     state_d = FULL;
        else if (bus.ready_i[owner_q])  state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= EMPTY;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      prod_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else if (accept) begin
      prod_q  <= mult_out;
      owner_q <= grant;
      last_q  <= grant;
    end
  end

  assign bus.ready_o   = ready;
  assign bus.valid_o   = (state_q == FULL) ? req_onehot(owner_q) : '0;
  assign bus.product_o = prod_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: handshake, contention, backpressure,
// reset and an operand sweep against a per-requester scoreboard.
module tb_mult_arbiter;

  localparam int W = 8;
  localparam int F = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mult_arbiter_if #(.width_p(W), .frac_p(F)) bus ();

  mult_arbiter #(.width_p(W), .frac_p(F)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int vals [9] = '{0, 1, 2, 3, 7, 15, 31, 127, 255};

  initial begin
    int idx0, idx1, got0, got1, cyc;
    logic [19:0] q0[$];
    logic [19:0] q1[$];
    logic [19:0] e;

    bus.valid_i = 2'b11;
    bus.ready_i = 2'b11;
    bus.a_i     = '0;
    bus.b_i     = '0;

    // reset state with requests pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_o", 32'(bus.ready_o), 32'h0);
    chk("rst_valid_o", 32'(bus.valid_o), 32'h0);
    chk("rst_product", 32'(bus.product_o), 32'h0);
    rst_n = 1'b1;

    // single op: 3.0 * 5 = 15.0
    bus.valid_i = 2'b01; bus.a_i[0] = 12'h030; bus.b_i[0] = 8'd5; bus.ready_i = 2'b00;
    #1 chk("single_ready", 32'(bus.ready_o), 32'h1);
    tick();
    bus.valid_i = 2'b00;
    #1;
    chk("single_valid", 32'(bus.valid_o), 32'h1);
    chk("single_prod", 32'(bus.product_o), 32'h0F0);
    bus.ready_i = 2'b01;
    tick();
    chk("single_drain", 32'(bus.valid_o), 32'h0);

    // contention straight after reset: 0,1,0,1
    rst_n = 1'b0; #1 rst_n = 1'b1;
    bus.valid_i = 2'b11; bus.ready_i = 2'b11;
    bus.a_i[0] = 12'h010; bus.b_i[0] = 8'd2;
    bus.a_i[1] = 12'h020; bus.b_i[1] = 8'd3;
    #1 chk("cont_ready0", 32'(bus.ready_o), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cont_valid", 32'(bus.valid_o), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("cont_prod", 32'(bus.product_o), (i % 2 == 0) ? 32'h020 : 32'h060);
      chk("cont_ready", 32'(bus.ready_o), (i % 2 == 0) ? 32'h2 : 32'h1);
    end
    bus.valid_i = 2'b00;
    tick();
    tick();
    chk("cont_empty", 32'(bus.valid_o), 32'h0);

    // backpressure on a req1 result; stray ready_i[0] must be ignored
    bus.valid_i = 2'b10; bus.a_i[1] = 12'h0A0; bus.b_i[1] = 8'd4; bus.ready_i = 2'b00;
    #1 chk("bp_ready1", 32'(bus.ready_o), 32'h2);
    tick();
    bus.valid_i = 2'b11; bus.a_i[0] = 12'h030; bus.b_i[0] = 8'd5;
    for (int i = 0; i < 3; i++) begin
      bus.ready_i = (i == 1) ? 2'b01 : 2'b00;
      #1;
      chk("bp_ready", 32'(bus.ready_o), 32'h0);
      chk("bp_valid", 32'(bus.valid_o), 32'h2);
      chk("bp_prod", 32'(bus.product_o), 32'h280);
      tick();
    end
    bus.ready_i = 2'b10;
    #1 chk("bp_release", 32'(bus.ready_o), 32'h1);
    tick();
    chk("bp_b2b_valid", 32'(bus.valid_o), 32'h1);
    chk("bp_b2b_prod", 32'(bus.product_o), 32'h0F0);

    // max operands
    bus.valid_i = 2'b01; bus.ready_i = 2'b01; bus.a_i[0] = 12'hFFF; bus.b_i[0] = 8'hFF;
    #1 chk("max_ready", 32'(bus.ready_o), 32'h1);
    tick();
    chk("max_valid", 32'(bus.valid_o), 32'h1);
    chk("max_prod", 32'(bus.product_o), 32'hFEF01);

    // reset while FULL
    bus.valid_i = 2'b11; bus.ready_i = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.valid_o), 32'h0);
    chk("mid_rst_ready", 32'(bus.ready_o), 32'h0);
    chk("mid_rst_prod", 32'(bus.product_o), 32'h0);
    #1 rst_n = 1'b1;
    bus.ready_i = 2'b11;
    #1 chk("post_rst_ready", 32'(bus.ready_o), 32'h1);
    tick();
    chk("post_rst_valid", 32'(bus.valid_o), 32'h1);
    chk("post_rst_prod", 32'(bus.product_o), 32'hFEF01);

    bus.valid_i = 2'b00;
    tick();
    tick();

    // operand sweep with random result backpressure
    idx0 = 0; idx1 = 0; got0 = 0; got1 = 0; cyc = 0;
    while (cyc < 400 && !(got0 == 9 && got1 == 9)) begin
      bus.valid_i[0] = (idx0 < 9);
      bus.valid_i[1] = (idx1 < 9);
      if (idx0 < 9) begin bus.a_i[0] = 12'(vals[idx0]); bus.b_i[0] = 8'(vals[(idx0 + 4) % 9]); end
      if (idx1 < 9) begin bus.a_i[1] = 12'(vals[8 - idx1]); bus.b_i[1] = 8'(vals[(idx1 + 2) % 9]); end
      bus.ready_i = (idx0 >= 9 && idx1 >= 9) ? 2'b11 : 2'($urandom_range(0, 3));
      #1;
      chk("sw_onehot", 32'($countones(bus.valid_o) <= 1), 32'h1);
      if (bus.valid_o[0] && bus.ready_i[0]) begin
        if (q0.size() == 0) chk("sw_q0_empty", 32'h0, 32'h1);
        else begin e = q0.pop_front(); chk("sw_prod0", 32'(bus.product_o), 32'(e)); got0++; end
      end
      if (bus.valid_o[1] && bus.ready_i[1]) begin
        if (q1.size() == 0) chk("sw_q1_empty", 32'h0, 32'h1);
        else begin e = q1.pop_front(); chk("sw_prod1", 32'(bus.product_o), 32'(e)); got1++; end
      end
      if (bus.valid_i[0] && bus.ready_o[0]) begin
        q0.push_back(20'(bus.a_i[0]) * 20'(bus.b_i[0]));
        idx0++;
      end
      if (bus.valid_i[1] && bus.ready_o[1]) begin
        q1.push_back(20'(bus.a_i[1]) * 20'(bus.b_i[1]));
        idx1++;
      end
      tick();
      cyc++;
    end
    chk("sw_got0", 32'(got0), 32'd9);
    chk("sw_got1", 32'(got1), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
